// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit geometry, field widths, flit type tags and head payload layout.
package ravenoc_pkg;

  localparam int FlitWidth     = 34;
  localparam int FlitDataWidth = FlitWidth - 2;
  localparam int XWidth        = 2;
  localparam int YWidth        = 2;
  localparam int PktWidth      = 8;
  localparam int MinDataWidth  = FlitDataWidth - XWidth - YWidth - PktWidth;
  localparam int VcWidth       = 2;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b01,
    BODY_FLIT = 2'b10,
    TAIL_FLIT = 2'b11
  } flit_type_t;

  // Layout of the data field of a HEAD flit, MSB first.
  typedef struct packed {
    logic [XWidth-1:0]       x_dest;
    logic [YWidth-1:0]       y_dest;
    logic [PktWidth-1:0]     pkt_size;
    logic [MinDataWidth-1:0] hdata;
  } s_flit_head_data_t;

endpackage

// File: rtl/flit_out_reg.sv
// One-slot valid/ready output register: holds a flit until the consumer takes it,
// and can refill in the same cycle it drains.
module flit_out_reg
  import ravenoc_pkg::*;
(
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 load_i,
  input  logic [FlitWidth-1:0] flit_i,
  input  logic                 ready_i,
  output logic [FlitWidth-1:0] fdata_o,
  output logic                 valid_o,
  output logic                 load_ok_o
);

  logic [FlitWidth-1:0] flit_q, flit_d;
  logic                 valid_q, valid_d;
  logic                 load;

  assign load_ok_o = !valid_q || ready_i;
  // A held flit is never overwritten before its handshake.
  assign load      = load_i && load_ok_o;

  // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    flit_d  = flit_q;
    valid_d = valid_q;
    if (load) begin
      flit_d  = flit_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (arst) begin
      // NOTE: the data slot is reset too, because fdata_o must read 0 straight after reset.
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      flit_q  <= flit_d;
      valid_q <= valid_d;
    end
  end

  assign fdata_o = flit_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/flit_packetizer.sv
// Serializes a packet descriptor plus payload words into HEAD/BODY/TAIL flits for a VC buffer.
// Optional macro FLIT_TX_STATS_EN adds saturating packet and flit handshake counters.
module flit_packetizer
  import ravenoc_pkg::*;
#(
  parameter int VcId = 0
`ifdef FLIT_TX_STATS_EN
  ,
  parameter int StatWidth = 16
`endif
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    pkt_valid_i,
  output logic                    pkt_ready_o,
  input  logic [XWidth-1:0]       x_dest_i,
  input  logic [YWidth-1:0]       y_dest_i,
  input  logic [PktWidth-1:0]     pkt_size_i,
  input  logic [MinDataWidth-1:0] head_data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  input  logic [FlitDataWidth-1:0] data_i,
  output logic [FlitWidth-1:0]    fdata_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [VcWidth-1:0]      vc_id_o,
  output logic                    busy_o
`ifdef FLIT_TX_STATS_EN
  ,
  output logic [StatWidth-1:0]    pkt_cnt_o,
  output logic [StatWidth-1:0]    flit_cnt_o
`endif
);

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } state_t;

  state_t               state_q, state_d;
  logic [PktWidth-1:0]  rem_q, rem_d;
  logic                 load_ok;
  logic                 load;
  logic [FlitWidth-1:0] flit_next;
  s_flit_head_data_t    head_fields;

  assign head_fields = '{
    x_dest:   x_dest_i,
    y_dest:   y_dest_i,
    pkt_size: pkt_size_i,
    hdata:    head_data_i
  };

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    load         = 1'b0;
    flit_next    = '0;
    pkt_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pkt_ready_o = load_ok;
        if (pkt_valid_i && load_ok) begin
          load      = 1'b1;
          flit_next = {HEAD_FLIT, head_fields};
          rem_d     = pkt_size_i;
          if (pkt_size_i != '0) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        data_ready_o = load_ok;
        if (data_valid_i && load_ok) begin
          load      = 1'b1;
          flit_next = (rem_q > PktWidth'(1)) ? {BODY_FLIT, data_i} : {TAIL_FLIT, data_i};
          // rem_q is at least 1 here, so the decrement cannot wrap.
          rem_d     = rem_q - PktWidth'(1);
          if (rem_q == PktWidth'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  flit_out_reg u_out_reg (
    .clk       (clk),
    .arst      (arst),
    .load_i    (load),
    .flit_i    (flit_next),
    .ready_i   (ready_i),
    .fdata_o   (fdata_o),
    .valid_o   (valid_o),
    .load_ok_o (load_ok)
  );

  assign vc_id_o = VcWidth'(VcId);
  assign busy_o  = (state_q != ST_IDLE) || valid_o;

`ifdef FLIT_TX_STATS_EN
  logic                 flit_hs, head_hs;
  logic [StatWidth-1:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;

  assign flit_hs = valid_o && ready_i;
  assign head_hs = flit_hs && (flit_type_t'(fdata_o[FlitWidth-1 -: 2]) == HEAD_FLIT);

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    if (head_hs && (pkt_cnt_q != '1))  pkt_cnt_d  = pkt_cnt_q + StatWidth'(1);
    if (flit_hs && (flit_cnt_q != '1)) flit_cnt_d = flit_cnt_q + StatWidth'(1);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// Self-checking bench for flit_packetizer: directed scenarios plus randomized traffic
// compared against an expected-flit queue built from packet-level rules.
module tb_flit_packetizer;
  import ravenoc_pkg::*;

  typedef logic [FlitWidth-1:0] flit_t;

  logic                     clk = 1'b0;
  logic                     arst;
  logic                     pkt_valid_i;
  logic                     pkt_ready_o;
  logic [XWidth-1:0]        x_dest_i;
  logic [YWidth-1:0]        y_dest_i;
  logic [PktWidth-1:0]      pkt_size_i;
  logic [MinDataWidth-1:0]  head_data_i;
  logic                     data_valid_i;
  logic                     data_ready_o;
  logic [FlitDataWidth-1:0] data_i;
  flit_t                    fdata_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [VcWidth-1:0]       vc_id_o;
  logic                     busy_o;
`ifdef FLIT_TX_STATS_EN
  logic [3:0]               pkt_cnt_o;
  logic [3:0]               flit_cnt_o;
`endif

`ifdef FLIT_TX_STATS_EN
  flit_packetizer #(.VcId(0), .StatWidth(4)) dut (
`else
  flit_packetizer #(.VcId(0)) dut (
`endif
    .clk          (clk),
    .arst         (arst),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_ready_o  (pkt_ready_o),
    .x_dest_i     (x_dest_i),
    .y_dest_i     (y_dest_i),
    .pkt_size_i   (pkt_size_i),
    .head_data_i  (head_data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .fdata_o      (fdata_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .vc_id_o      (vc_id_o),
    .busy_o       (busy_o)
`ifdef FLIT_TX_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o),
    .flit_cnt_o   (flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  flit_t got_q[$];
  flit_t exp_q[$];
  int    got_base = 0;
  int    exp_base = 0;
  int    stall_viol = 0;
  int    leak_viol = 0;
  flit_t prev_data = '0;
  logic  prev_stall = 1'b0;
  bit    rand_done;

  // Observes the interface mid-cycle: a flit seen with valid&&ready here transfers at the next edge.
  always @(negedge clk) begin
    if (arst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!valid_o || fdata_o !== prev_data)) stall_viol <= stall_viol + 1;
      if (data_ready_o && pkt_ready_o) leak_viol <= leak_viol + 1;
      if (valid_o && ready_i) got_q.push_back(fdata_o);
      prev_stall <= valid_o && !ready_i;
      prev_data  <= fdata_o;
    end
  end

  function automatic flit_t head_f(input logic [XWidth-1:0] x, input logic [YWidth-1:0] y,
                                   input logic [PktWidth-1:0] s,
                                   input logic [MinDataWidth-1:0] hd);
    return {HEAD_FLIT, x, y, s, hd};
  endfunction

  function automatic flit_t pay_f(input logic [FlitDataWidth-1:0] d, input bit last);
    return last ? {TAIL_FLIT, d} : {BODY_FLIT, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [XWidth-1:0] x, input logic [YWidth-1:0] y,
                           input logic [PktWidth-1:0] s, input logic [MinDataWidth-1:0] hd,
                           output int waits);
    logic acc;
    pkt_valid_i = 1'b1;
    x_dest_i    = x;
    y_dest_i    = y;
    pkt_size_i  = s;
    head_data_i = hd;
    exp_q.push_back(head_f(x, y, s, hd));
    waits = 0;
    forever begin
      @(negedge clk);
      acc = pkt_ready_o;
      step();
      if (acc) break;
      waits++;
      if (waits > 500) begin
        checks++;
        errors++;
        $display("FAIL desc_timeout: no accept after %0d cycles, required accept", waits);
        break;
      end
    end
    pkt_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [FlitDataWidth-1:0] d, input bit last, output int waits);
    logic acc;
    data_valid_i = 1'b1;
    data_i       = d;
    exp_q.push_back(pay_f(d, last));
    waits = 0;
    forever begin
      @(negedge clk);
      acc = data_ready_o;
      step();
      if (acc) break;
      waits++;
      if (waits > 500) begin
        checks++;
        errors++;
        $display("FAIL word_timeout: no accept after %0d cycles, required accept", waits);
        break;
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int size, input int gap_max);
    int w;
    send_desc(2'($urandom), 2'($urandom), PktWidth'(size), MinDataWidth'($urandom), w);
    for (int i = 0; i < size; i++) begin
      repeat ($urandom_range(0, gap_max)) step();
      send_word($urandom, i == size - 1, w);
    end
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1'b1;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy_o=%b after %0d cycles, required 0", busy_o, n);
    end
    step();
  endtask

  task automatic compare(input string name);
    int ng = got_q.size() - got_base;
    int ne = exp_q.size() - exp_base;
    checks++;
    if (ng != ne) begin
      errors++;
      $display("FAIL %s_count: got %0d flits, required %0d", name, ng, ne);
    end
    for (int i = 0; i < ng && i < ne; i++) begin
      checks++;
      if (got_q[got_base+i] !== exp_q[exp_base+i]) begin
        errors++;
        $display("FAIL %s_flit%0d: got %h, required %h", name, i, got_q[got_base+i],
                 exp_q[exp_base+i]);
      end
    end
    checks++;
    if (stall_viol != 0 || leak_viol != 0) begin
      errors++;
      $display("FAIL %s_protocol: stall_viol=%0d leak_viol=%0d, required 0 and 0", name,
               stall_viol, leak_viol);
    end
    got_base = got_q.size();
    exp_base = exp_q.size();
  endtask

  task automatic do_reset();
    arst         = 1'b1;
    pkt_valid_i  = 1'b0;
    data_valid_i = 1'b0;
    ready_i      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    if (fdata_o !== '0) begin errors++; $display("FAIL rst_fdata: got %h, required 0", fdata_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rst_dready: got %b, required 0", data_ready_o); end
    if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b, required 1", pkt_ready_o); end
    if (vc_id_o !== '0) begin errors++; $display("FAIL rst_vcid: got %h, required 0", vc_id_o); end
    checks += 6;
`ifdef FLIT_TX_STATS_EN
    checks++;
    if (pkt_cnt_o !== 4'd0 || flit_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL rst_stats: got %0d/%0d, required 0/0", pkt_cnt_o, flit_cnt_o);
    end
`endif
    got_base = got_q.size();
    exp_base = exp_q.size();
  endtask

  task automatic test_head_only();
    int w;
    ready_i = 1'b1;
    send_desc(2'd1, 2'd2, 8'd0, 20'hAB, w);
    checks += 3;
    if (valid_o !== 1'b1 || fdata_o !== head_f(2'd1, 2'd2, 8'd0, 20'hAB)) begin
      errors++;
      $display("FAIL head_only_flit: got v=%b %h, required v=1 %h", valid_o, fdata_o,
               head_f(2'd1, 2'd2, 8'd0, 20'hAB));
    end
    if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL head_only_pready: got %b, required 1", pkt_ready_o); end
    if (data_ready_o !== 1'b0) begin errors++; $display("FAIL head_only_dready: got %b, required 0", data_ready_o); end
    step();
    checks++;
    if (valid_o !== 1'b0 || data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL head_only_after: got v=%b dr=%b, required 0 0", valid_o, data_ready_o);
    end
    compare("head_only");
  endtask

  task automatic test_burst();
    int w, tot;
    logic [FlitDataWidth-1:0] words[3];
    words[0] = 32'h11;
    words[1] = 32'h22;
    words[2] = 32'h33;
    ready_i = 1'b1;
    send_desc(2'd3, 2'd1, 8'd3, 20'h5, w);
    tot = w;
    checks++;
    if (fdata_o !== head_f(2'd3, 2'd1, 8'd3, 20'h5)) begin
      errors++;
      $display("FAIL burst_head: got %h, required %h", fdata_o, head_f(2'd3, 2'd1, 8'd3, 20'h5));
    end
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], i == 2, w);
      tot += w;
      checks++;
      if (valid_o !== 1'b1 || fdata_o !== pay_f(words[i], i == 2)) begin
        errors++;
        $display("FAIL burst_word%0d: got v=%b %h, required v=1 %h", i, valid_o, fdata_o,
                 pay_f(words[i], i == 2));
      end
    end
    checks++;
    if (tot != 0) begin errors++; $display("FAIL burst_stalls: got %0d stall cycles, required 0", tot); end
    step();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b, required 0", busy_o); end
    compare("burst");
  endtask

  task automatic test_back_to_back();
    int w;
    ready_i = 1'b1;
    send_desc(2'd0, 2'd3, 8'd1, 20'h123, w);
    send_word(32'hCAFE0001, 1'b1, w);
    send_desc(2'd2, 2'd0, 8'd0, 20'h456, w);
    checks += 2;
    if (w != 0) begin errors++; $display("FAIL b2b_bubble: got %0d wait cycles, required 0", w); end
    if (fdata_o !== head_f(2'd2, 2'd0, 8'd0, 20'h456)) begin
      errors++;
      $display("FAIL b2b_head: got %h, required %h", fdata_o, head_f(2'd2, 2'd0, 8'd0, 20'h456));
    end
    drain();
    compare("b2b");
  endtask

  task automatic test_backpressure();
    int w;
    flit_t hd;
    ready_i = 1'b0;
    send_desc(2'd2, 2'd3, 8'd2, 20'h77, w);
    hd = head_f(2'd2, 2'd3, 8'd2, 20'h77);
    data_valid_i = 1'b1;
    data_i       = 32'hA5A5_0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || fdata_o !== hd || data_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b dr=%b %h, required v=1 dr=0 %h", k, valid_o,
                 data_ready_o, fdata_o, hd);
      end
      step();
    end
    ready_i = 1'b1;
    send_word(32'hA5A5_0001, 1'b0, w);
    checks++;
    if (fdata_o !== pay_f(32'hA5A5_0001, 1'b0)) begin
      errors++;
      $display("FAIL bp_body: got %h, required %h", fdata_o, pay_f(32'hA5A5_0001, 1'b0));
    end
    send_word(32'hA5A5_0002, 1'b1, w);
    drain();
    compare("backpressure");
  endtask

  task automatic test_payload_gap();
    int w;
    ready_i = 1'b1;
    send_desc(2'd1, 2'd1, 8'd2, 20'h9, w);
    send_word(32'h0000_BEEF, 1'b0, w);
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid%0d: got %b, required 0", k, valid_o); end
      step();
    end
    send_word(32'h0000_F00D, 1'b1, w);
    checks++;
    if (fdata_o !== pay_f(32'h0000_F00D, 1'b1)) begin
      errors++;
      $display("FAIL gap_tail: got %h, required %h", fdata_o, pay_f(32'h0000_F00D, 1'b1));
    end
    drain();
    compare("gap");
  endtask

  task automatic test_reset_mid();
    int w;
    ready_i = 1'b1;
    send_desc(2'd3, 2'd3, 8'd3, 20'h1, w);
    send_word(32'h1111_2222, 1'b0, w);
    arst = 1'b1;
    step();
    arst = 1'b0;
    checks += 2;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", valid_o); end
    if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_pready: got %b, required 1", pkt_ready_o); end
    got_base = got_q.size();
    exp_base = exp_q.size();
    send_desc(2'd0, 2'd1, 8'd1, 20'h2, w);
    checks++;
    if (fdata_o !== head_f(2'd0, 2'd1, 8'd1, 20'h2)) begin
      errors++;
      $display("FAIL midrst_head: got %h, required %h", fdata_o, head_f(2'd0, 2'd1, 8'd1, 20'h2));
    end
    send_word(32'h3333_4444, 1'b1, w);
    drain();
    compare("midrst");
  endtask

  task automatic test_random();
    rand_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++) send_pkt($urandom_range(0, 6), 2);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    compare("random");
  endtask

`ifdef FLIT_TX_STATS_EN
  task automatic test_stats();
    int w;
    do_reset();
    got_base = got_q.size();
    exp_base = exp_q.size();
    for (int p = 0; p < 20; p++) begin
      send_desc(2'd1, 2'd0, 8'd0, MinDataWidth'(p), w);
      if (p == 4) begin
        drain();
        checks++;
        if (pkt_cnt_o !== 4'd5) begin errors++; $display("FAIL stats_mid: got %0d, required 5", pkt_cnt_o); end
      end
    end
    drain();
    checks++;
    if (pkt_cnt_o !== 4'hF || flit_cnt_o !== 4'hF) begin
      errors++;
      $display("FAIL stats_sat: got %0d/%0d, required 15/15", pkt_cnt_o, flit_cnt_o);
    end
    compare("stats");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    arst         = 1'b1;
    pkt_valid_i  = 1'b0;
    data_valid_i = 1'b0;
    ready_i      = 1'b1;
    x_dest_i     = '0;
    y_dest_i     = '0;
    pkt_size_i   = '0;
    head_data_i  = '0;
    data_i       = '0;
    test_reset();
    test_head_only();
    test_burst();
    test_back_to_back();
    test_backpressure();
    test_payload_gap();
    test_reset_mid();
    test_random();
`ifdef FLIT_TX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flit_packetizer.md
Name: flit_packetizer

Overview:
- Transmit-side counterpart of the router virtual-channel input buffer.
- Accepts one packet descriptor (destination, size, head payload) plus a stream of payload words, and serializes them into HEAD, BODY and TAIL flits.
- Drives the flit valid/ready interface consumed by a VC buffer.
- Sits in the NI/local-port path, ahead of the router local input.

Parameters:
- VcId, 0, VC tag driven on vc_id_o for every flit of this instance.
- StatWidth, 16, width of statistics counters (used only with FLIT_TX_STATS_EN).

Ports:
- clk  in  1  clock
- arst  in  1  reset; synchronous, active-high, sampled on posedge clk only
- pkt_valid_i  in  1  packet descriptor valid
- pkt_ready_o  out  1  descriptor accepted when pkt_valid_i && pkt_ready_o
- x_dest_i  in  XWidth  destination X
- y_dest_i  in  YWidth  destination Y
- pkt_size_i  in  PktWidth  number of flits following the head (0 = head-only packet)
- head_data_i  in  MinDataWidth  payload carried in the head flit
- data_valid_i  in  1  payload word valid
- data_ready_o  out  1  payload word accepted when data_valid_i && data_ready_o
- data_i  in  FlitDataWidth  payload word for a BODY/TAIL flit
- fdata_o  out  FlitWidth  flit to VC buffer
- valid_o  out  1  flit valid
- ready_i  in  1  VC buffer ready
- vc_id_o  out  VcWidth  constant VcId
- busy_o  out  1  packet in progress (state != ST_IDLE or valid_o)

Behaviour:
- Reset: all outputs 0, with one exception: pkt_ready_o = 1 in the first cycle after reset. Reset state is ST_IDLE, remaining counter is 0 and the output register is empty.
- Output stage: one registered flit slot (flit_ff, valid_ff); fdata_o = flit_ff and valid_o = valid_ff.
- The slot may load when load_ok = !valid_ff || ready_i.
- Once valid_o rises, fdata_o holds stable until ready_i; valid_o never drops without a handshake.
- FSM states:
  - ST_IDLE: pkt_ready_o = load_ok. On descriptor accept, load a HEAD flit {HEAD_FLIT, x_dest_i, y_dest_i, pkt_size_i, head_data_i} and set rem = pkt_size_i. If pkt_size_i == 0, stay in ST_IDLE; otherwise go to ST_PAYLOAD.
  - ST_PAYLOAD: pkt_ready_o = 0 and data_ready_o = load_ok. On word accept, load {BODY_FLIT, data_i} if rem > 1, else {TAIL_FLIT, data_i}, then rem decrements. When rem reaches 0, go to ST_IDLE.
- Latency: descriptor or word accepted in cycle t → flit visible on fdata_o/valid_o in cycle t+1.
- Throughput: 1 flit/cycle with ready_i held high and data_valid_i continuous.
- Back-to-back packets: a new descriptor is accepted in the cycle the TAIL handshakes, with no bubble.
- Payload stall: with data_valid_i low, valid_o deasserts after the pending flit drains. This is legal because the receiver stays route-locked until the TAIL arrives.
- data_ready_o = 0 in ST_IDLE; payload words never leak across packets.
- Simultaneous load and drain: if ready_i && valid_ff in the same cycle as a load, the new flit replaces the old one and valid_o stays 1.
- rem width is PktWidth. No wrap is possible, because decrement happens only in ST_PAYLOAD with rem ≥ 1.
- Reset mid-packet: return to ST_IDLE and discard the slot. The downstream VC buffer shares the reset, so its lock clears too.

Optional Feature:
- Macro: FLIT_TX_STATS_EN.
- Defined: adds pkt_cnt_o [StatWidth-1:0] (increments on each HEAD handshake) and flit_cnt_o [StatWidth-1:0] (increments on each flit handshake). Both saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent.

Decomposition:
- ravenoc_pkg holds the following; no new package items are needed except FlitDataWidth:
  - FlitWidth, FlitDataWidth (= FlitWidth - 2), XWidth, YWidth, PktWidth, MinDataWidth, VcWidth
  - flit type enum HEAD_FLIT / BODY_FLIT / TAIL_FLIT
  - s_flit_head_data_t
- The FSM state enum is local.
- One natural sub-module: flit_out_reg, the one-slot valid/ready output register.

Test Plan:
1. Reset, then descriptor x=1, y=2, size=0, head_data=0xAB with ready_i=1 → one HEAD flit with pkt_size 0 next cycle; pkt_ready_o high the following cycle; data_ready_o never high.
2. size=3, payload 0x11, 0x22, 0x33 continuous, ready_i=1 → HEAD, BODY(0x11), BODY(0x22), TAIL(0x33) in 4 consecutive cycles; busy_o low afterwards.
3. size=2 with ready_i low for 5 cycles after the HEAD appears → fdata_o stable and valid_o high throughout; data_ready_o low; BODY follows on release.
4. size=2 with a 3-cycle data_valid_i gap between words → valid_o low during the gap; TAIL carries the second word; no extra flits.
5. Assert arst while in ST_PAYLOAD with rem=2 → next cycle valid_o=0, pkt_ready_o=1; next descriptor starts with a HEAD.
6. With FLIT_TX_STATS_EN and StatWidth=4: send 20 head-only packets → pkt_cnt_o saturates at 15.
